xdff_bank_arbiter: RTL and testbench

Round-robin arbiter and command sequencer for a shared W-bit register bank built from set/reset D flip-flop cells. Up to NREQ requesters issue LOAD, SET, CLR or HOLD commands over a four-phase req/ack handshake. The block grants one requester at a time, applies its command to the bank, and acknowledges completion. It sits between the control agents and the register bank, and is the only writer of the bank.

---
 rtl/xdff_bank_arbiter.sv | 137 +++++++++++++
 tb/tb_xdff_bank_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/xdff_bank_arbiter.sv
// Round-robin arbiter and command sequencer for a shared set/reset flip-flop register bank.
// One requester at a time is granted, its command applied to Q, and completion acknowledged.
module xdff_bank_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk0,
  input  logic              Ra,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  input  logic [W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              ack,
  output logic              busy,
  output logic [W-1:0]      Q,
  output logic [7:0]        txn_cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] CmdLoad = 2'b00;
  localparam logic [1:0] CmdSet  = 2'b01;
  localparam logic [1:0] CmdClr  = 2'b10;
  localparam logic [1:0] CmdHold = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StAck   = 2'b10
  } state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx_q;

  logic [IW-1:0] cand;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          sel_req;
  logic [1:0]    sel_cmd;
  logic [W-1:0]  sel_wdata;
  logic [IW-1:0] ptr_next;

  // Search starting at ptr_q and wrapping; first set request bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Request, command and data of the currently granted requester.
  always_comb begin
    sel_req   = 1'b0;
    sel_cmd   = CmdHold;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_req   = req[i];
        sel_cmd   = cmd[2*i +: 2];
        sel_wdata = wdata[W*i +: W];
      end
    end
  end

  always_comb begin
    if (32'(gidx_q) == NREQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = gidx_q + IW'(1);
    end
  end

  always_ff @(posedge clk0 or posedge Ra) begin
    if (Ra) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt     <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      Q       <= '0;
      txn_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            gidx_q  <= win_idx;
            gnt     <= NREQ'(1) << win_idx;
            busy    <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (sel_req) begin
            unique case (sel_cmd)
              CmdLoad: Q <= sel_wdata;
              CmdSet:  Q <= '1;
              CmdClr:  Q <= '0;
              CmdHold: Q <= Q;
            endcase
            ack     <= 1'b1;
            state_q <= StAck;
          end else begin
            // Abort: requester withdrew before the command was applied.
            gnt     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StAck: begin
          if (!sel_req) begin
            ack     <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr_q   <= ptr_next;
            txn_cnt <= txn_cnt + 8'd1;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt     <= '0;
          ack     <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xdff_bank_arbiter.sv
// Directed, table-driven bench for xdff_bank_arbiter (NREQ=4, W=8).
module tb_xdff_bank_arbiter;

  logic        clk0;
  logic        Ra;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        ack;
  logic        busy;
  logic [7:0]  Q;
  logic [7:0]  txn_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  xdff_bank_arbiter #(
    .NREQ(4),
    .W   (8)
  ) dut (
    .clk0   (clk0),
    .Ra     (Ra),
    .req    (req),
    .cmd    (cmd),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .busy   (busy),
    .Q      (Q),
    .txn_cnt(txn_cnt)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        ack;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  txn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic e_ack,
                         input logic e_busy, input logic [7:0] e_q, input logic [7:0] e_txn);
    chk({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, " ack"}, 32'(ack), 32'(e_ack));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " Q"}, 32'(Q), 32'(e_q));
    chk({tag, " txn_cnt"}, 32'(txn_cnt), 32'(e_txn));
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic [7:0] c, input logic [3:0] g,
                     input logic a, input logic b, input logic [7:0] q, input logic [7:0] t);
    vec_t v;
    v.req   = r;
    v.cmd   = c;
    v.wdata = 32'h003C_00A5;
    v.gnt   = g;
    v.ack   = a;
    v.busy  = b;
    v.q     = q;
    v.txn   = t;
    vecs.push_back(v);
  endtask

  initial begin
    // Single LOAD by requester 0 (cmd0=LOAD, wdata0=A5).
    add(4'b0001, 8'hC8, 4'b0001, 1'b0, 1'b1, 8'h00, 8'd0);
    add(4'b0001, 8'hC8, 4'b0001, 1'b1, 1'b1, 8'hA5, 8'd0);
    add(4'b0000, 8'hC8, 4'b0000, 1'b0, 1'b0, 8'hA5, 8'd1);
    // Contention, ptr=1: cmds r0 SET, r1 CLR, r2 LOAD 3C, r3 HOLD; order 1,2,3,0.
    add(4'b1111, 8'hC9, 4'b0010, 1'b0, 1'b1, 8'hA5, 8'd1);
    add(4'b1111, 8'hC9, 4'b0010, 1'b1, 1'b1, 8'h00, 8'd1);
    add(4'b1101, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h00, 8'd2);
    add(4'b1111, 8'hC9, 4'b0100, 1'b0, 1'b1, 8'h00, 8'd2);
    add(4'b1111, 8'hC9, 4'b0100, 1'b1, 1'b1, 8'h3C, 8'd2);
    add(4'b1011, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'd3);
    add(4'b1111, 8'hC9, 4'b1000, 1'b0, 1'b1, 8'h3C, 8'd3);
    add(4'b1111, 8'hC9, 4'b1000, 1'b1, 1'b1, 8'h3C, 8'd3);
    add(4'b0111, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'd4);
    add(4'b1111, 8'hC9, 4'b0001, 1'b0, 1'b1, 8'h3C, 8'd4);
    add(4'b1111, 8'hC9, 4'b0001, 1'b1, 1'b1, 8'hFF, 8'd4);
    add(4'b1111, 8'hC9, 4'b0001, 1'b1, 1'b1, 8'hFF, 8'd4);
    add(4'b1110, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'hFF, 8'd5);
    // Fairness: serve 2, then 0101 must pick 0, then 2.
    add(4'b0100, 8'hC9, 4'b0100, 1'b0, 1'b1, 8'hFF, 8'd5);
    add(4'b0100, 8'hC9, 4'b0100, 1'b1, 1'b1, 8'h3C, 8'd5);
    add(4'b0000, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'd6);
    add(4'b0101, 8'hC9, 4'b0001, 1'b0, 1'b1, 8'h3C, 8'd6);
    add(4'b0101, 8'hC9, 4'b0001, 1'b1, 1'b1, 8'hFF, 8'd6);
    add(4'b0100, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'hFF, 8'd7);
    add(4'b0100, 8'hC9, 4'b0100, 1'b0, 1'b1, 8'hFF, 8'd7);
    add(4'b0100, 8'hC9, 4'b0100, 1'b1, 1'b1, 8'h3C, 8'd7);
    add(4'b0000, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'd8);
    // Abort by requester 1 with ptr=3; ptr must stay 3 so 0110 then picks 1, not 2.
    add(4'b0010, 8'hC9, 4'b0010, 1'b0, 1'b1, 8'h3C, 8'd8);
    add(4'b0000, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'd8);
    add(4'b0110, 8'hC9, 4'b0010, 1'b0, 1'b1, 8'h3C, 8'd8);
    add(4'b0110, 8'hC9, 4'b0010, 1'b1, 1'b1, 8'h00, 8'd8);
    add(4'b0100, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h00, 8'd9);
    add(4'b0000, 8'hC9, 4'b0000, 1'b0, 1'b0, 8'h00, 8'd9);

    // Reset with random inputs toggling.
    Ra    = 1'b1;
    req   = 4'($urandom);
    cmd   = 8'($urandom);
    wdata = $urandom;
    #1;
    chk_all("reset async", 4'b0000, 1'b0, 1'b0, 8'h00, 8'd0);
    for (int i = 0; i < 3; i++) begin
      req   = 4'($urandom);
      cmd   = 8'($urandom);
      wdata = $urandom;
      step();
      chk_all("reset held", 4'b0000, 1'b0, 1'b0, 8'h00, 8'd0);
    end
    req = 4'b0000;
    Ra  = 1'b0;
    step();
    step();
    chk_all("reset release idle", 4'b0000, 1'b0, 1'b0, 8'h00, 8'd0);

    foreach (vecs[i]) begin
      req   = vecs[i].req;
      cmd   = vecs[i].cmd;
      wdata = vecs[i].wdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].busy, vecs[i].q,
              vecs[i].txn);
    end

    // Reset while in ACK: everything clears without a clock edge.
    req = 4'b0001;
    cmd = 8'hC9;
    step();
    step();
    chk_all("pre-reset ack", 4'b0001, 1'b1, 1'b1, 8'hFF, 8'd9);
    #2;
    Ra = 1'b1;
    #1;
    chk_all("reset in ack", 4'b0000, 1'b0, 1'b0, 8'h00, 8'd0);
    req = 4'b0000;
    #1;
    Ra = 1'b0;

    // 256 LOAD transactions by requester 0; txn_cnt wraps 255 -> 0.
    cmd = 8'h00;
    for (int n = 1; n <= 256; n++) begin
      wdata = 32'(n[7:0]);
      req   = 4'b0001;
      step();
      step();
      req = 4'b0000;
      step();
      if (n == 1) chk_all("wrap first", 4'b0000, 1'b0, 1'b0, 8'h01, 8'd1);
      if (n == 255) chk_all("wrap 255", 4'b0000, 1'b0, 1'b0, 8'hFF, 8'd255);
      if (n == 256) chk_all("wrap 256", 4'b0000, 1'b0, 1'b0, 8'h00, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
